// File: rtl/calc_defs_pkg.sv
// Shared calculator definitions: converter FSM encoding and elaboration-time sizing helpers.
package calc_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 32'd0) ? value - 32'd1 : 32'd0;
        r = 32'd0;
        while (v > 32'd0) begin
            r = r + 32'd1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Smallest D with 10**D >= 2**bin_w, i.e. floor(bin_w*log10(2)) + 1.
    function automatic int unsigned min_digits(input int unsigned bin_w);
        longint unsigned scaled;
        scaled = 64'(bin_w) * 64'd30103;
        return 32'(scaled / 64'd100000) + 32'd1;
    endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble correction: every BCD digit >= 5 gets +3 (4-bit wrap, no inter-digit carry).
module bcd_add3_stage #(
    parameter int unsigned DIGITS = 8
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    output logic [4*DIGITS-1:0] bcd_o
);

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        assign bcd_o[4*g +: 4] = (bcd_i[4*g +: 4] >= 4'd5) ? bcd_i[4*g +: 4] + 4'd3
                                                            : bcd_i[4*g +: 4];
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one double-dabble step per clock, valid/ready on both sides.
// Optional leading-zero blank output enabled with `define BIN2BCD_SEQ_BLANK_EN.
module bin2bcd_seq
    import calc_defs_pkg::*;
#(
    parameter int unsigned BIN_W  = 28,
    parameter int unsigned DIGITS = 9,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [BIN_W-1:0]    bin_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                sign_o
`ifdef BIN2BCD_SEQ_BLANK_EN
    ,
    output logic [DIGITS-1:0]   blank_o
`endif
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = clog2(BIN_W + 1);

    if (BIN_W < 4) begin : g_bad_bin_w
        $error("bin2bcd_seq: BIN_W must be at least 4");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small, 10**DIGITS < 2**BIN_W");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [BIN_W-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [ACC_W-1:0] bcd_q, bcd_d;
    logic             sign_q, sign_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] acc_corr;
    logic [ACC_W-1:0] acc_shift;
    logic             accept_c;
    logic             last_step_c;
    logic             neg_in_c;
    logic             unused_acc_msb;

    bcd_add3_stage #(.DIGITS(DIGITS)) u_add3 (
        .bcd_i (acc_q),
        .bcd_o (acc_corr)
    );

    // The corrected MSB shifts out; the DIGITS range check guarantees it is always zero.
    assign unused_acc_msb = acc_corr[ACC_W-1];
    assign acc_shift      = {acc_corr[ACC_W-2:0], mag_q[BIN_W-1]};

    assign in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
    assign accept_c    = in_valid_i && in_ready_o;
    assign last_step_c = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(1));
    assign neg_in_c    = SIGNED && bin_i[BIN_W-1];

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        bcd_d       = bcd_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                acc_d = acc_shift;
                mag_d = {mag_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step_c) begin
                    state_d     = ST_DONE;
                    bcd_d       = acc_shift;
                    sign_d      = neg_q;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Capture from IDLE or straight out of DONE when the result is consumed.
        if (accept_c) begin
            state_d     = ST_SHIFT;
            cnt_d       = CNT_W'(BIN_W);
            acc_d       = '0;
            neg_d       = neg_in_c;
            mag_d       = neg_in_c ? (~bin_i + BIN_W'(1)) : bin_i;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            bcd_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            bcd_q       <= bcd_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign sign_o      = sign_q;
    assign out_valid_o = out_valid_q;

`ifdef BIN2BCD_SEQ_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Digit i blanks when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        blank_d  = blank_q;
        zero_run = 1'b1;
        if (last_step_c) begin
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                zero_run   = zero_run && (acc_shift[4*i +: 4] == 4'd0);
                blank_d[i] = zero_run;
            end
            blank_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_o = blank_q;
`endif

endmodule
